// File: rtl/base_rrgate_arb.sv
// base_rrgate_arb: packet-gated round-robin arbiter.
// Picks one of `ways` requester streams, holds it for a whole packet, and
// rotates priority to the requester after the winner at every end-of-packet.
//
// Handshake semantics (both sides): a beat moves on a rising clk edge exactly
// when valid and ready are both 1. A requester's valid does not wait for its
// ready. Ready may depend combinationally on valid (i_r follows o_r & o_v).
// Data and end-of-packet are only meaningful while valid is 1.
module base_rrgate_arb #(
  parameter int ways  = 4,
  parameter int width = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ways-1:0]          i_v,
  output logic [ways-1:0]          i_r,
  input  logic [ways*width-1:0]    i_d,
  input  logic [ways-1:0]          i_e,
  input  logic [ways-1:0]          i_en,
  input  logic                     quiesce,
  output logic                     o_v,
  input  logic                     o_r,
  output logic [width-1:0]         o_d,
  output logic                     o_e,
  output logic [$clog2(ways)-1:0]  o_s,
  output logic                     o_idle,
  output logic                     o_dbg_state
);

  localparam int SW  = $clog2(ways);
  localparam int SWP = SW + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   owner_q, owner_d;
  logic [SW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            idle_q, idle_d;

  logic [ways-1:0] elig;
  logic            any_elig;
  logic [SW-1:0]   rr_sel;
  logic            rr_found;
  logic [SWP-1:0]  idx_w;
  logic [SW-1:0]   sel;
  logic [SW-1:0]   ptr_next;
  logic            lock;
  logic            xfer;

  assign lock = (state_q == ST_LOCK);

  // Requesters allowed to open a new packet; quiesce blocks every start.
  assign elig     = quiesce ? '0 : (i_v & i_en);
  assign any_elig = |elig;

  // Round-robin search: first eligible index at or after rr_ptr, wrapping.
  always_comb begin
    rr_sel   = rr_ptr_q;
    rr_found = 1'b0;
    idx_w    = '0;
    for (int off = 0; off < ways; off++) begin
      idx_w = {1'b0, rr_ptr_q} + SWP'(off);
      if (idx_w >= SWP'(ways)) begin
        idx_w = idx_w - SWP'(ways);
      end
      if (!rr_found && elig[idx_w[SW-1:0]]) begin
        rr_found = 1'b1;
        rr_sel   = idx_w[SW-1:0];
      end
    end
  end

  // An open packet pins the selection to its owner; otherwise arbitrate.
  assign sel = lock ? owner_q : rr_sel;

  // Output beat is a straight mux of the selected requester.
  always_comb begin
    o_v = ~reset & i_v[sel] & (lock | any_elig);
    o_d = i_d[int'(sel)*width +: width];
    o_e = i_e[sel];
    o_s = sel;
  end

  assign xfer = o_v & o_r;

  // Only the selected requester ever sees ready.
  always_comb begin
    i_r = '0;
    for (int k = 0; k < ways; k++) begin
      if (SW'(k) == sel) begin
        i_r[k] = xfer;
      end
    end
  end

  // Priority moves to the requester after the one that just finished.
  assign ptr_next = (sel == SW'(ways - 1)) ? '0 : sel + 1'b1;

  // Next-state: open on a non-final beat, close on a final beat.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    idle_d   = idle_q;
    if (xfer) begin
      if (o_e) begin
        state_d  = ST_IDLE;
        idle_d   = 1'b1;
        rr_ptr_d = ptr_next;
      end else begin
        state_d  = ST_LOCK;
        idle_d   = 1'b0;
        owner_d  = sel;
      end
    end
  end

  // State registers; reset abandons any open packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      idle_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      idle_q   <= idle_d;
    end
  end

  // While reset is held the block already reports idle.
  assign o_idle      = idle_q | reset;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_base_rrgate_arb.sv
// Bench for base_rrgate_arb: directed scenarios plus randomized traffic
// checked against a packet-level reference model.
module tb_base_rrgate_arb;

  localparam int WAYS = 4;
  localparam int W    = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [WAYS-1:0]   i_v = '0;
  logic [WAYS-1:0]   i_r;
  logic [WAYS*W-1:0] i_d = '0;
  logic [WAYS-1:0]   i_e = '0;
  logic [WAYS-1:0]   i_en = '0;
  logic              quiesce = 1'b0;
  logic              o_v;
  logic              o_r = 1'b0;
  logic [W-1:0]      o_d;
  logic              o_e;
  logic [1:0]        o_s;
  logic              o_idle;
  logic              o_dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W-1:0] exp_q[$];

  base_rrgate_arb #(.ways(WAYS), .width(W)) dut (
    .clk(clk), .reset(reset),
    .i_v(i_v), .i_r(i_r), .i_d(i_d), .i_e(i_e), .i_en(i_en),
    .quiesce(quiesce),
    .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_e(o_e), .o_s(o_s),
    .o_idle(o_idle), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] data_of(input int k, input int c);
    return {32'hD00D_0000 | 32'(k), 32'(c)};
  endfunction

  // driver: apply one cycle of inputs at negedge, settle before checking
  task automatic drive(input logic [WAYS-1:0] v, input logic [WAYS-1:0] en,
                       input logic [WAYS-1:0] e, input logic q, input logic r);
    @(negedge clk);
    cyc++;
    i_v = v; i_en = en; i_e = e; quiesce = q; o_r = r;
    for (int k = 0; k < WAYS; k++) i_d[k*W +: W] = data_of(k, cyc);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; i_v = '0; i_e = '0; i_en = '0; quiesce = 1'b0; o_r = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; i_v = 4'b1111; i_en = 4'b1111; i_e = 4'b0000; o_r = 1'b1;
    #2;
    checks++; if (o_v !== 1'b0) begin errors++; $display("FAIL reset_o_v got=%b exp=0", o_v); end
    checks++; if (i_r !== 4'b0000) begin errors++; $display("FAIL reset_i_r got=%b exp=0000", i_r); end
    checks++; if (o_idle !== 1'b1) begin errors++; $display("FAIL reset_o_idle got=%b exp=1", o_idle); end
    @(negedge clk);
    #2;
    checks++; if (o_v !== 1'b0 || o_idle !== 1'b1) begin errors++; $display("FAIL reset_hold got o_v=%b o_idle=%b exp 0/1", o_v, o_idle); end
    do_reset();
  endtask

  // Scenario 1: all valid, single-beat packets -> 0,1,2,3,0
  task automatic test_rotate();
    do_reset();
    for (int n = 0; n < 5; n++) begin
      drive(4'b1111, 4'b1111, 4'b1111, 1'b0, 1'b1);
      checks++; if (o_v !== 1'b1) begin errors++; $display("FAIL rotate_o_v n=%0d got=%b exp=1", n, o_v); end
      checks++; if (o_s !== 2'(n % 4)) begin errors++; $display("FAIL rotate_o_s n=%0d got=%0d exp=%0d", n, o_s, n % 4); end
      checks++; if (i_r !== 4'(1 << (n % 4))) begin errors++; $display("FAIL rotate_i_r n=%0d got=%b exp=%b", n, i_r, 4'(1 << (n % 4))); end
      checks++; if (o_d !== data_of(n % 4, cyc)) begin errors++; $display("FAIL rotate_o_d n=%0d got=%h exp=%h", n, o_d, data_of(n % 4, cyc)); end
    end
  endtask

  // Scenario 2: requester 2 holds a 3-beat packet while requester 0 waits
  task automatic test_packet_hold();
    logic [WAYS-1:0] ends [3];
    ends[0] = 4'b0000; ends[1] = 4'b0000; ends[2] = 4'b0100;
    do_reset();
    drive(4'b0011, 4'b1111, 4'b0011, 1'b0, 1'b1);
    drive(4'b0011, 4'b1111, 4'b0011, 1'b0, 1'b1);
    checks++; if (o_s !== 2'd1) begin errors++; $display("FAIL hold_prefix got=%0d exp=1", o_s); end
    for (int b = 0; b < 3; b++) begin
      drive(4'b0101, 4'b1111, ends[b], 1'b0, 1'b1);
      checks++; if (o_v !== 1'b1 || o_s !== 2'd2) begin errors++; $display("FAIL hold_o_s beat=%0d got v=%b s=%0d exp v=1 s=2", b, o_v, o_s); end
      checks++; if (i_r !== 4'b0100) begin errors++; $display("FAIL hold_i_r beat=%0d got=%b exp=0100", b, i_r); end
      checks++; if (o_e !== ends[b][2]) begin errors++; $display("FAIL hold_o_e beat=%0d got=%b exp=%b", b, o_e, ends[b][2]); end
    end
    drive(4'b0001, 4'b1111, 4'b0001, 1'b0, 1'b1);
    checks++; if (o_v !== 1'b1 || o_s !== 2'd0) begin errors++; $display("FAIL hold_after got v=%b s=%0d exp v=1 s=0", o_v, o_s); end
  endtask

  // Scenario 3: owner bubble holds the output even with another requester valid
  task automatic test_bubble();
    do_reset();
    drive(4'b0010, 4'b1111, 4'b0000, 1'b0, 1'b1);
    checks++; if (o_s !== 2'd1 || o_v !== 1'b1) begin errors++; $display("FAIL bubble_open got v=%b s=%0d exp v=1 s=1", o_v, o_s); end
    for (int n = 0; n < 2; n++) begin
      drive(4'b1000, 4'b1111, 4'b1000, 1'b0, 1'b1);
      checks++; if (o_v !== 1'b0 || i_r !== 4'b0000) begin errors++; $display("FAIL bubble_gap n=%0d got v=%b r=%b exp v=0 r=0000", n, o_v, i_r); end
      checks++; if (o_idle !== 1'b0) begin errors++; $display("FAIL bubble_idle n=%0d got=%b exp=0", n, o_idle); end
    end
    drive(4'b1010, 4'b1111, 4'b1010, 1'b0, 1'b1);
    checks++; if (o_v !== 1'b1 || o_s !== 2'd1 || o_e !== 1'b1) begin errors++; $display("FAIL bubble_resume got v=%b s=%0d e=%b exp 1/1/1", o_v, o_s, o_e); end
    drive(4'b1000, 4'b1111, 4'b1000, 1'b0, 1'b1);
    checks++; if (o_v !== 1'b1 || o_s !== 2'd3) begin errors++; $display("FAIL bubble_next got v=%b s=%0d exp v=1 s=3", o_v, o_s); end
  endtask

  // Scenario 4: quiesce mid-packet lets the packet finish then blocks starts
  task automatic test_quiesce();
    logic [WAYS-1:0] ends [4];
    logic            qs   [4];
    ends[0] = 4'b0000; ends[1] = 4'b0000; ends[2] = 4'b0000; ends[3] = 4'b0001;
    qs[0] = 1'b0; qs[1] = 1'b1; qs[2] = 1'b1; qs[3] = 1'b1;
    do_reset();
    for (int b = 0; b < 4; b++) begin
      drive(4'b1111, 4'b1111, ends[b], qs[b], 1'b1);
      checks++; if (o_v !== 1'b1 || o_s !== 2'd0 || i_r !== 4'b0001) begin errors++; $display("FAIL quiesce_beat b=%0d got v=%b s=%0d r=%b exp 1/0/0001", b, o_v, o_s, i_r); end
    end
    for (int n = 0; n < 3; n++) begin
      drive(4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b1);
      checks++; if (o_v !== 1'b0 || o_idle !== 1'b1 || i_r !== 4'b0000) begin errors++; $display("FAIL quiesce_block n=%0d got v=%b idle=%b r=%b exp 0/1/0000", n, o_v, o_idle, i_r); end
    end
    drive(4'b1111, 4'b1111, 4'b1111, 1'b0, 1'b1);
    checks++; if (o_v !== 1'b1 || o_s !== 2'd1) begin errors++; $display("FAIL quiesce_release got v=%b s=%0d exp v=1 s=1", o_v, o_s); end
  endtask

  // Scenario 5: enable mask restricts grants to 1 and 3
  task automatic test_enable_mask();
    do_reset();
    for (int n = 0; n < 4; n++) begin
      drive(4'b1111, 4'b1010, 4'b1111, 1'b0, 1'b1);
      checks++; if (o_v !== 1'b1 || o_s !== ((n % 2 == 0) ? 2'd1 : 2'd3)) begin errors++; $display("FAIL enmask n=%0d got v=%b s=%0d exp v=1 s=%0d", n, o_v, o_s, (n % 2 == 0) ? 1 : 3); end
    end
  endtask

  // Scenario 6: reset while locked on requester 3
  task automatic test_reset_in_lock();
    do_reset();
    drive(4'b1000, 4'b1111, 4'b0000, 1'b0, 1'b1);
    drive(4'b1001, 4'b1111, 4'b0000, 1'b0, 1'b1);
    checks++; if (o_s !== 2'd3 || o_idle !== 1'b0) begin errors++; $display("FAIL rstlock_open got s=%0d idle=%b exp s=3 idle=0", o_s, o_idle); end
    @(negedge clk);
    reset = 1'b1;
    #2;
    checks++; if (o_v !== 1'b0 || o_idle !== 1'b1 || i_r !== 4'b0000) begin errors++; $display("FAIL rstlock_during got v=%b idle=%b r=%b exp 0/1/0000", o_v, o_idle, i_r); end
    @(negedge clk);
    reset = 1'b0; i_v = 4'b1001; i_e = 4'b1001;
    #2;
    checks++; if (o_v !== 1'b1 || o_s !== 2'd0 || o_idle !== 1'b1) begin errors++; $display("FAIL rstlock_after got v=%b s=%0d idle=%b exp 1/0/1", o_v, o_s, o_idle); end
  endtask

  // Randomized traffic against a packet-level model
  task automatic test_random();
    int           rem    [WAYS];
    logic [W-1:0] head_d [WAYS];
    logic         head_e [WAYS];
    int           open_owner;
    int           ptr;
    int           s;
    logic         ev;
    logic [WAYS-1:0] v, en, e_vec, ir_exp;
    logic         q, r;
    logic [W-1:0] want;
    do_reset();
    open_owner = -1;
    ptr = 0;
    en = 4'b1111;
    for (int k = 0; k < WAYS; k++) begin
      rem[k] = $urandom_range(1, 4);
      head_d[k] = {$urandom, $urandom};
      head_e[k] = (rem[k] == 1);
    end
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < WAYS; k++) v[k] = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 9) == 0) en = 4'($urandom_range(0, 15));
      q = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < WAYS; k++) e_vec[k] = head_e[k];
      @(negedge clk);
      i_v = v; i_en = en; i_e = e_vec; quiesce = q; o_r = r;
      for (int k = 0; k < WAYS; k++) i_d[k*W +: W] = head_d[k];
      #2;
      // model: an open packet keeps its owner, else first eligible from ptr
      s = 0;
      ev = 1'b0;
      if (open_owner >= 0) begin
        s = open_owner;
        ev = v[s];
      end else if (!q) begin
        for (int off = 0; off < WAYS; off++) begin
          int c;
          c = (ptr + off) % WAYS;
          if (!ev && v[c] && en[c]) begin ev = 1'b1; s = c; end
        end
      end
      ir_exp = (ev && r) ? 4'(1 << s) : 4'b0000;
      checks++; if (o_v !== ev) begin errors++; $display("FAIL rand_o_v n=%0d got=%b exp=%b", n, o_v, ev); end
      checks++; if (i_r !== ir_exp) begin errors++; $display("FAIL rand_i_r n=%0d got=%b exp=%b", n, i_r, ir_exp); end
      checks++; if (o_idle !== (open_owner < 0)) begin errors++; $display("FAIL rand_o_idle n=%0d got=%b exp=%b", n, o_idle, open_owner < 0); end
      if (ev) begin
        checks++; if (o_s !== 2'(s) || o_e !== head_e[s]) begin errors++; $display("FAIL rand_sel n=%0d got s=%0d e=%b exp s=%0d e=%b", n, o_s, o_e, s, head_e[s]); end
      end
      if (ev && r) exp_q.push_back(head_d[s]);
      if (o_v === 1'b1 && r) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (o_d !== want) begin errors++; $display("FAIL rand_o_d n=%0d got=%h exp=%h", n, o_d, want); end
      end
      if (ev && r) begin
        if (head_e[s]) begin
          open_owner = -1;
          ptr = (s + 1) % WAYS;
        end else begin
          open_owner = s;
        end
        rem[s] = rem[s] - 1;
        if (rem[s] == 0) rem[s] = $urandom_range(1, 4);
        head_d[s] = {$urandom, $urandom};
        head_e[s] = (rem[s] == 1);
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_packet_hold();
    test_bubble();
    test_quiesce();
    test_enable_mask();
    test_reset_in_lock();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
